// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: states, opcodes,
// funct codes, EXT/ALU/PC/write-data selects and the decoded control bundle.
package mc_ctrl_fsm_pkg;

  typedef enum logic [2:0] {S_IF, S_ID, S_EXE, S_MEM, S_WB} state_e;

  typedef enum logic [2:0] {C_ALU, C_BEQ, C_J, C_LW, C_SW} cls_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [1:0] EXT_ZERO    = 2'b00;
  localparam logic [1:0] EXT_SIGNED  = 2'b01;
  localparam logic [1:0] EXT_HIGHPOS = 2'b10;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_NOR  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_DM  = 2'b01;
  localparam logic [1:0] WD_IMM = 2'b10;

  typedef struct packed {
    cls_e       cls;
    logic [1:0] ext_op;
    logic [3:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] wd_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{cls: C_ALU, ext_op: EXT_ZERO, alu_op: ALU_ADD,
                                  alu_src: 1'b0, reg_dst: 1'b0, wd_sel: WD_ALU};

  // Returns {valid, alu_op} for an R-type funct field.
  function automatic logic [4:0] r_alu(input logic [5:0] funct);
    case (funct)
      FN_ADD, FN_ADDU: return {1'b1, ALU_ADD};
      FN_SUB, FN_SUBU: return {1'b1, ALU_SUB};
      FN_AND:          return {1'b1, ALU_AND};
      FN_OR:           return {1'b1, ALU_OR};
      FN_XOR:          return {1'b1, ALU_XOR};
      FN_NOR:          return {1'b1, ALU_NOR};
      FN_SLT:          return {1'b1, ALU_SLT};
      FN_SLTU:         return {1'b1, ALU_SLTU};
      default:         return {1'b0, ALU_NOP};
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath signal bundle. master = sequencer, slave = datapath.
interface mc_ctrl_fsm_if #(
  parameter int unsigned ALUOP_W = 4
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               zero;
  logic               mem_rdy;
  logic               pc_wr;
  logic [1:0]         pc_src;
  logic               ir_wr;
  logic               reg_wr;
  logic               reg_dst;
  logic [1:0]         wd_sel;
  logic               alu_src;
  logic [ALUOP_W-1:0] alu_op;
  logic [1:0]         ext_op;
  logic               mem_req;
  logic               mem_we;
  logic               illegal;
  logic               mem_err;
  logic               instr_done;

  modport master (
    input  opcode, funct, zero, mem_rdy,
    output pc_wr, pc_src, ir_wr, reg_wr, reg_dst, wd_sel, alu_src, alu_op,
           ext_op, mem_req, mem_we, illegal, mem_err, instr_done
  );

  modport slave (
    output opcode, funct, zero, mem_rdy,
    input  pc_wr, pc_src, ir_wr, reg_wr, reg_dst, wd_sel, alu_src, alu_op,
           ext_op, mem_req, mem_we, illegal, mem_err, instr_done
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode/funct decoder producing the datapath control bundle and
// an illegal flag for undecoded opcodes or R-type funct values.
module mc_ctrl_decode
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       illegal
);

  logic [4:0] rdec;

  always_comb begin
    rdec    = r_alu(funct);
    ctrl    = CTRL_IDLE;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (rdec[4]) begin
          ctrl.reg_dst = 1'b1;
          ctrl.alu_op  = rdec[3:0];
        end else begin
          illegal = 1'b1;
        end
      end
      OP_J: ctrl.cls = C_J;
      OP_BEQ: begin
        ctrl.cls    = C_BEQ;
        ctrl.ext_op = EXT_SIGNED;
        ctrl.alu_op = ALU_SUB;
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl.ext_op  = EXT_SIGNED;
        ctrl.alu_src = 1'b1;
      end
      OP_ANDI: begin
        ctrl.alu_op  = ALU_AND;
        ctrl.alu_src = 1'b1;
      end
      OP_ORI: begin
        ctrl.alu_op  = ALU_OR;
        ctrl.alu_src = 1'b1;
      end
      OP_LUI: begin
        ctrl.ext_op  = EXT_HIGHPOS;
        ctrl.alu_src = 1'b1;
        ctrl.wd_sel  = WD_IMM;
      end
      OP_LW: begin
        ctrl.cls     = C_LW;
        ctrl.ext_op  = EXT_SIGNED;
        ctrl.alu_src = 1'b1;
        ctrl.wd_sel  = WD_DM;
      end
      OP_SW: begin
        ctrl.cls     = C_SW;
        ctrl.ext_op  = EXT_SIGNED;
        ctrl.alu_src = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer (IF->ID->EXE->MEM->WB) with memory-wait timeout.
// Optional MC_CTRL_PERF_EN adds free-running cycle and retired-instruction counters.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned MEM_TMO = 15
) (
  input  logic        clk,
  input  logic        rstn,
  mc_ctrl_fsm_if.master bus
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ins_cnt
`endif
);

  localparam int unsigned CW = (MEM_TMO < 2) ? 1 : $clog2(MEM_TMO + 1);

  state_e        state;
  ctrl_t         dec;
  ctrl_t         dreg;
  logic          dec_ill;
  logic [CW-1:0] wcnt;
  logic          ir_wr_q, pc_wr_q, reg_wr_q, mem_req_q, mem_we_q, done_q, beq_q;
  logic [1:0]    pc_src_q;
  logic          in_id, in_mem, ill_hit, tmo_hit, done;

  mc_ctrl_decode u_dec (
    .opcode  (bus.opcode),
    .funct   (bus.funct),
    .ctrl    (dec),
    .illegal (dec_ill)
  );

  assign in_id   = (state == S_ID);
  assign in_mem  = (state == S_MEM);
  assign ill_hit = in_id & dec_ill;
  assign tmo_hit = (MEM_TMO != 0) && in_mem && !bus.mem_rdy && (wcnt == CW'(MEM_TMO));

  // Outputs are registered on state entry; only the terms that depend on inputs
  // arriving inside a state (zero, mem_rdy, the ID decode) are merged combinationally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IF;
      dreg      <= CTRL_IDLE;
      wcnt      <= '0;
      ir_wr_q   <= 1'b0;
      pc_wr_q   <= 1'b0;
      reg_wr_q  <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      done_q    <= 1'b0;
      beq_q     <= 1'b0;
      pc_src_q  <= PC_PLUS4;
    end else begin
      ir_wr_q  <= 1'b0;
      pc_wr_q  <= 1'b0;
      reg_wr_q <= 1'b0;
      done_q   <= 1'b0;
      beq_q    <= 1'b0;
      pc_src_q <= PC_PLUS4;
      case (state)
        S_IF: begin
          // Coming out of reset the fetch strobes are low, so spend one cycle raising them.
          if (ir_wr_q) begin
            state <= S_ID;
          end else begin
            ir_wr_q <= 1'b1;
            pc_wr_q <= 1'b1;
          end
        end
        S_ID: begin
          if (dec_ill) begin
            state   <= S_IF;
            ir_wr_q <= 1'b1;
            pc_wr_q <= 1'b1;
            dreg    <= CTRL_IDLE;
          end else begin
            state <= S_EXE;
            dreg  <= dec;
            case (dec.cls)
              C_BEQ: begin
                beq_q    <= 1'b1;
                pc_src_q <= PC_BRANCH;
                done_q   <= 1'b1;
              end
              C_J: begin
                pc_wr_q  <= 1'b1;
                pc_src_q <= PC_JUMP;
                done_q   <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_EXE: begin
          case (dreg.cls)
            C_BEQ, C_J: begin
              state   <= S_IF;
              ir_wr_q <= 1'b1;
              pc_wr_q <= 1'b1;
              dreg    <= CTRL_IDLE;
            end
            C_LW, C_SW: begin
              state     <= S_MEM;
              mem_req_q <= 1'b1;
              mem_we_q  <= (dreg.cls == C_SW);
              wcnt      <= '0;
            end
            default: begin
              state    <= S_WB;
              reg_wr_q <= 1'b1;
              done_q   <= 1'b1;
            end
          endcase
        end
        S_MEM: begin
          if (bus.mem_rdy) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (dreg.cls == C_LW) begin
              state    <= S_WB;
              reg_wr_q <= 1'b1;
              done_q   <= 1'b1;
            end else begin
              state   <= S_IF;
              ir_wr_q <= 1'b1;
              pc_wr_q <= 1'b1;
              dreg    <= CTRL_IDLE;
            end
          end else if (tmo_hit) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state     <= S_IF;
            ir_wr_q   <= 1'b1;
            pc_wr_q   <= 1'b1;
            dreg      <= CTRL_IDLE;
          end else begin
            wcnt <= wcnt + CW'(1);
          end
        end
        S_WB: begin
          state   <= S_IF;
          ir_wr_q <= 1'b1;
          pc_wr_q <= 1'b1;
          dreg    <= CTRL_IDLE;
        end
        default: state <= S_IF;
      endcase
    end
  end

  assign done = done_q | ill_hit | (in_mem & bus.mem_rdy & (dreg.cls == C_SW)) | tmo_hit;

  assign bus.ir_wr      = ir_wr_q;
  assign bus.pc_wr      = pc_wr_q | (beq_q & bus.zero);
  assign bus.pc_src     = pc_src_q;
  assign bus.reg_wr     = reg_wr_q;
  assign bus.reg_dst    = in_id ? dec.reg_dst : dreg.reg_dst;
  assign bus.wd_sel     = in_id ? dec.wd_sel : dreg.wd_sel;
  assign bus.alu_src    = in_id ? dec.alu_src : dreg.alu_src;
  assign bus.alu_op     = ALUOP_W'(in_id ? dec.alu_op : dreg.alu_op);
  assign bus.ext_op     = in_id ? dec.ext_op : dreg.ext_op;
  assign bus.mem_req    = mem_req_q & ~tmo_hit;
  assign bus.mem_we     = mem_we_q & ~tmo_hit;
  assign bus.illegal    = ill_hit;
  assign bus.mem_err    = tmo_hit;
  assign bus.instr_done = done;

`ifdef MC_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc_cnt <= '0;
      ins_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (done) ins_cnt <= ins_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: the stimulus pushes the expected output
// snapshot for every cycle; a negedge monitor pops and compares.
module tb_mc_ctrl_fsm;
  import mc_ctrl_fsm_pkg::*;

  localparam int K_ALU = 0, K_BEQ = 1, K_J = 2, K_LW = 3, K_SW = 4, K_ILL = 5;
  localparam int TMO = 3;

  typedef struct packed {
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       ir_wr;
    logic       reg_wr;
    logic       reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src;
    logic [3:0] alu_op;
    logic [1:0] ext_op;
    logic       mem_req;
    logic       mem_we;
    logic       illegal;
    logic       mem_err;
    logic       instr_done;
  } obs_t;

  typedef struct packed {
    logic [1:0] ext;
    logic [3:0] alu;
    logic       src;
    logic       dst;
    logic [1:0] wd;
  } dec_t;

  logic clk = 1'b0;
  logic rstn;
  int   nvec = 0;
  int   nfail = 0;
  obs_t exp_q[$];
  string tag_q[$];
  obs_t act, ex;
  string tg;

  always #5 clk = ~clk;

  mc_ctrl_fsm_if #(.ALUOP_W(4)) bus ();

  mc_ctrl_fsm #(.ALUOP_W(4), .MEM_TMO(TMO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      ex = exp_q.pop_front();
      tg = tag_q.pop_front();
      act = '{pc_wr: bus.pc_wr, pc_src: bus.pc_src, ir_wr: bus.ir_wr, reg_wr: bus.reg_wr,
              reg_dst: bus.reg_dst, wd_sel: bus.wd_sel, alu_src: bus.alu_src,
              alu_op: bus.alu_op, ext_op: bus.ext_op, mem_req: bus.mem_req,
              mem_we: bus.mem_we, illegal: bus.illegal, mem_err: bus.mem_err,
              instr_done: bus.instr_done};
      nvec++;
      if (act !== ex) begin
        nfail++;
        $display("FAIL %s @%0t: got %b required %b", tg, $time, act, ex);
      end
    end
  end

  function automatic obs_t o_idle();
    obs_t o = '0;
    o.alu_op = ALU_ADD;
    return o;
  endfunction

  function automatic obs_t o_if();
    obs_t o = o_idle();
    o.pc_wr = 1'b1;
    o.ir_wr = 1'b1;
    return o;
  endfunction

  function automatic dec_t mkd(logic [1:0] ext, logic [3:0] alu, logic src, logic dst,
                               logic [1:0] wd);
    return '{ext: ext, alu: alu, src: src, dst: dst, wd: wd};
  endfunction

  task automatic step(input obs_t e, input string tag, input logic rdy, input logic z,
                      input logic rst);
    @(posedge clk);
    #1;
    rstn        = rst;
    bus.mem_rdy = rdy;
    bus.zero    = z;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic run(input string nm, input logic [5:0] op, input logic [5:0] fn,
                     input dec_t d, input int kind, input logic z, input int nwait,
                     input bit tmo, input bit noise);
    obs_t e, x, m;
    step(o_if(), {nm, "/if"}, noise, 1'b0, 1'b1);
    bus.opcode = op;
    bus.funct  = fn;
    e = o_idle();
    e.ext_op  = d.ext;
    e.alu_op  = d.alu;
    e.alu_src = d.src;
    e.reg_dst = d.dst;
    e.wd_sel  = d.wd;
    if (kind == K_ILL) begin
      e.illegal    = 1'b1;
      e.instr_done = 1'b1;
      step(e, {nm, "/id"}, noise, 1'b0, 1'b1);
      return;
    end
    step(e, {nm, "/id"}, noise, 1'b0, 1'b1);
    x = e;
    if (kind == K_BEQ || kind == K_J) begin
      x.pc_wr      = (kind == K_J) ? 1'b1 : z;
      x.pc_src     = (kind == K_J) ? PC_JUMP : PC_BRANCH;
      x.instr_done = 1'b1;
      step(x, {nm, "/exe"}, noise, z, 1'b1);
      return;
    end
    step(x, {nm, "/exe"}, noise, z, 1'b1);
    if (kind == K_LW || kind == K_SW) begin
      for (int i = 0; i <= nwait; i++) begin
        m = x;
        m.mem_req = 1'b1;
        m.mem_we  = (kind == K_SW);
        if (i == nwait && tmo) begin
          m.mem_req    = 1'b0;
          m.mem_we     = 1'b0;
          m.mem_err    = 1'b1;
          m.instr_done = 1'b1;
        end else if (i == nwait && kind == K_SW) begin
          m.instr_done = 1'b1;
        end
        step(m, {nm, "/mem"}, (i == nwait) && !tmo, 1'b0, 1'b1);
      end
      if (tmo || kind == K_SW) return;
    end
    x.reg_wr     = 1'b1;
    x.instr_done = 1'b1;
    step(x, {nm, "/wb"}, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    obs_t e;
    dec_t d_sw;
    rstn        = 1'b0;
    bus.opcode  = '0;
    bus.funct   = '0;
    bus.zero    = 1'b0;
    bus.mem_rdy = 1'b0;
    d_sw = mkd(EXT_SIGNED, ALU_ADD, 1'b1, 1'b0, WD_ALU);

    step(o_idle(), "reset", 1'b0, 1'b0, 1'b0);
    step(o_idle(), "primer", 1'b0, 1'b0, 1'b1);

    run("ori", OP_ORI, 6'h00, mkd(EXT_ZERO, ALU_OR, 1'b1, 1'b0, WD_ALU), K_ALU, 1'b0, 0, 0, 1);
    run("lui", OP_LUI, 6'h00, mkd(EXT_HIGHPOS, ALU_ADD, 1'b1, 1'b0, WD_IMM), K_ALU, 1'b0, 0, 0, 0);
    run("addi", OP_ADDI, 6'h00, mkd(EXT_SIGNED, ALU_ADD, 1'b1, 1'b0, WD_ALU), K_ALU, 1'b0, 0, 0, 0);
    run("andi", OP_ANDI, 6'h00, mkd(EXT_ZERO, ALU_AND, 1'b1, 1'b0, WD_ALU), K_ALU, 1'b0, 0, 0, 0);
    run("add", OP_RTYPE, FN_ADD, mkd(EXT_ZERO, ALU_ADD, 1'b0, 1'b1, WD_ALU), K_ALU, 1'b1, 0, 0, 0);
    run("sub", OP_RTYPE, FN_SUB, mkd(EXT_ZERO, ALU_SUB, 1'b0, 1'b1, WD_ALU), K_ALU, 1'b0, 0, 0, 0);
    run("slt", OP_RTYPE, FN_SLT, mkd(EXT_ZERO, ALU_SLT, 1'b0, 1'b1, WD_ALU), K_ALU, 1'b0, 0, 0, 0);
    run("lw_w3", OP_LW, 6'h00, mkd(EXT_SIGNED, ALU_ADD, 1'b1, 1'b0, WD_DM), K_LW, 1'b0, 3, 0, 1);
    run("lw_w0", OP_LW, 6'h00, mkd(EXT_SIGNED, ALU_ADD, 1'b1, 1'b0, WD_DM), K_LW, 1'b0, 0, 0, 0);
    run("sw_w0", OP_SW, 6'h00, d_sw, K_SW, 1'b0, 0, 0, 0);
    run("sw_w2", OP_SW, 6'h00, d_sw, K_SW, 1'b0, 2, 0, 0);
    run("beq_t", OP_BEQ, 6'h00, mkd(EXT_SIGNED, ALU_SUB, 1'b0, 1'b0, WD_ALU), K_BEQ, 1'b1, 0, 0, 0);
    run("beq_nt", OP_BEQ, 6'h00, mkd(EXT_SIGNED, ALU_SUB, 1'b0, 1'b0, WD_ALU), K_BEQ, 1'b0, 0, 0, 0);
    run("j", OP_J, 6'h00, mkd(EXT_ZERO, ALU_ADD, 1'b0, 1'b0, WD_ALU), K_J, 1'b0, 0, 0, 1);
    run("ill_op", 6'h3F, 6'h00, mkd(EXT_ZERO, ALU_ADD, 1'b0, 1'b0, WD_ALU), K_ILL, 1'b0, 0, 0, 0);
    run("ill_fn", OP_RTYPE, 6'h3F, mkd(EXT_ZERO, ALU_ADD, 1'b0, 1'b0, WD_ALU), K_ILL, 1'b0, 0, 0, 0);
    run("lw_tmo", OP_LW, 6'h00, mkd(EXT_SIGNED, ALU_ADD, 1'b1, 1'b0, WD_DM), K_LW, 1'b0, TMO, 1, 0);
    run("sw_tmo", OP_SW, 6'h00, d_sw, K_SW, 1'b0, TMO, 1, 0);

    // sw interrupted by reset after one memory wait cycle
    step(o_if(), "sw_rst/if", 1'b0, 1'b0, 1'b1);
    bus.opcode = OP_SW;
    bus.funct  = 6'h00;
    e = o_idle();
    e.ext_op  = EXT_SIGNED;
    e.alu_src = 1'b1;
    step(e, "sw_rst/id", 1'b0, 1'b0, 1'b1);
    step(e, "sw_rst/exe", 1'b0, 1'b0, 1'b1);
    e.mem_req = 1'b1;
    e.mem_we  = 1'b1;
    step(e, "sw_rst/mem", 1'b0, 1'b0, 1'b1);
    step(o_idle(), "sw_rst/async", 1'b0, 1'b0, 1'b0);
    step(o_idle(), "sw_rst/primer", 1'b0, 1'b0, 1'b1);
    run("ori_post", OP_ORI, 6'h00, mkd(EXT_ZERO, ALU_OR, 1'b1, 1'b0, WD_ALU), K_ALU, 1'b0, 0, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      nfail++;
      $display("FAIL drain: %0d entries pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
